// File: rtl/sd_cmd_engine_if.sv
// rtl/sd_cmd_engine_if.sv - byte exchange handshake between the command engine and the SPI byte stage
interface sd_cmd_engine_if;
    logic [7:0] TxByte;
    logic       ByteStart;
    logic       ByteDone;
    logic [7:0] RxByte;

    modport master (output TxByte, output ByteStart, input ByteDone, input RxByte);
    modport slave  (input TxByte, input ByteStart, output ByteDone, output RxByte);
endinterface

// File: rtl/sd_cmd_engine.sv
// rtl/sd_cmd_engine.sv - SD SPI command sequencer: frame with CRC7, R1 polling, response collection
module sd_cmd_engine #(
    parameter int NCR_MAX     = 8,
    parameter int TRAIL_BYTES = 1
) (
    input  logic                MasterCLK,
    input  logic                Reset,
    input  logic                CmdStart,
    input  logic [5:0]          CmdIndex,
    input  logic [31:0]         CmdArg,
    input  logic [2:0]          RespLen,
    output logic                Busy,
    output logic                CmdDone,
    output logic                Timeout,
    output logic [7:0]          R1,
    output logic [31:0]         RespData,
    output logic                CS_Enable,
    sd_cmd_engine_if.master     byteBus
);
    localparam int PW = (NCR_MAX < 1) ? 1 : $clog2(NCR_MAX + 1);
    localparam int TW = (TRAIL_BYTES < 1) ? 1 : $clog2(TRAIL_BYTES + 1);

    typedef enum logic [2:0] {IDLE, SEND, POLL, RESP, TRAIL} engineState_e;

    engineState_e   state, stateNext;
    logic           pending;
    logic           issue;
    logic           gotByte;
    logic [47:0]    frame;
    logic [2:0]     byteCnt;
    logic [PW-1:0]  pollCnt;
    logic [2:0]     respLenQ;
    logic [2:0]     respCnt;
    logic [TW-1:0]  trailCnt;
    logic [31:0]    respShift;
    logic [5:0]     alignShift;

    function automatic logic [6:0] crc7(input logic [39:0] bits);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = bits[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // A byte is outstanding from the edge after ByteStart until ByteDone is seen.
    assign gotByte    = pending && byteBus.ByteDone;
    assign respShift  = {RespData[23:0], byteBus.RxByte};
    assign alignShift = {3'd4 - respLenQ, 3'b000};

    always_ff @(posedge MasterCLK) begin
        if (!Reset) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext         = state;
        issue             = 1'b0;
        CmdDone           = 1'b0;
        byteBus.TxByte    = 8'hFF;
        case (state)
            IDLE: begin
                if (CmdStart) stateNext = SEND;
            end
            SEND: begin
                issue          = !pending;
                byteBus.TxByte = frame[47:40];
                if (gotByte && byteCnt == 3'd5) stateNext = POLL;
            end
            POLL: begin
                issue = !pending;
                if (gotByte) begin
                    if (!byteBus.RxByte[7])
                        stateNext = (respLenQ == 3'd0) ? TRAIL : RESP;
                    else if (pollCnt == PW'(NCR_MAX - 1))
                        stateNext = TRAIL;
                end
            end
            RESP: begin
                issue = !pending;
                if (gotByte && respCnt == respLenQ - 3'd1) stateNext = TRAIL;
            end
            TRAIL: begin
                if (trailCnt == TW'(TRAIL_BYTES)) begin
                    CmdDone   = 1'b1;
                    stateNext = IDLE;
                end else begin
                    issue = !pending;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign byteBus.ByteStart = issue;
    assign Busy              = (state != IDLE);
    assign CS_Enable         = (state == SEND) || (state == POLL) || (state == RESP);

    always_ff @(posedge MasterCLK) begin
        if (!Reset) begin
            pending  <= 1'b0;
            frame    <= '1;
            byteCnt  <= '0;
            pollCnt  <= '0;
            respLenQ <= '0;
            respCnt  <= '0;
            trailCnt <= '0;
            Timeout  <= 1'b0;
            R1       <= 8'hFF;
            RespData <= '0;
        end else begin
            if (issue)        pending <= 1'b1;
            else if (gotByte) pending <= 1'b0;

            case (state)
                IDLE: begin
                    if (CmdStart) begin
                        frame    <= {2'b01, CmdIndex, CmdArg,
                                     crc7({2'b01, CmdIndex, CmdArg}), 1'b1};
                        respLenQ <= (RespLen > 3'd4) ? 3'd4 : RespLen;
                        byteCnt  <= '0;
                        pollCnt  <= '0;
                        respCnt  <= '0;
                        trailCnt <= '0;
                        pending  <= 1'b0;
                        Timeout  <= 1'b0;
                        RespData <= '0;
                    end
                end
                SEND: begin
                    if (gotByte) begin
                        frame   <= {frame[39:0], 8'hFF};
                        byteCnt <= byteCnt + 3'd1;
                    end
                end
                POLL: begin
                    if (gotByte) begin
                        if (!byteBus.RxByte[7]) begin
                            R1 <= byteBus.RxByte;
                        end else begin
                            pollCnt <= pollCnt + 1'b1;
                            if (pollCnt == PW'(NCR_MAX - 1)) begin
                                Timeout <= 1'b1;
                                R1      <= 8'hFF;
                            end
                        end
                    end
                end
                RESP: begin
                    if (gotByte) begin
                        respCnt <= respCnt + 3'd1;
                        // Short responses are pushed up so the first byte lands in [31:24].
                        if (respCnt == respLenQ - 3'd1) RespData <= respShift << alignShift;
                        else                            RespData <= respShift;
                    end
                end
                TRAIL: begin
                    if (gotByte) trailCnt <= trailCnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_cmd_engine.sv
// tb/tb_sd_cmd_engine.sv - randomized bench for sd_cmd_engine against a queue-based command model
module tb_sd_cmd_engine;
    localparam int NCR   = 8;
    localparam int TRAIL = 1;

    logic        MasterCLK = 1'b0;
    logic        Reset;
    logic        CmdStart;
    logic [5:0]  CmdIndex;
    logic [31:0] CmdArg;
    logic [2:0]  RespLen;
    logic        Busy, CmdDone, Timeout, CS_Enable;
    logic [7:0]  R1;
    logic [31:0] RespData;

    sd_cmd_engine_if bus ();

    sd_cmd_engine #(.NCR_MAX(NCR), .TRAIL_BYTES(TRAIL)) dut (
        .MasterCLK (MasterCLK),
        .Reset     (Reset),
        .CmdStart  (CmdStart),
        .CmdIndex  (CmdIndex),
        .CmdArg    (CmdArg),
        .RespLen   (RespLen),
        .Busy      (Busy),
        .CmdDone   (CmdDone),
        .Timeout   (Timeout),
        .R1        (R1),
        .RespData  (RespData),
        .CS_Enable (CS_Enable),
        .byteBus   (bus)
    );

    always #5 MasterCLK = ~MasterCLK;

    int checks = 0;
    int errors = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // SPI byte stage model: records each exchanged byte and answers from rxQ.
    logic [7:0] rxQ[$];
    logic [7:0] recTx[$];
    logic       recCs[$];
    logic       outstanding = 1'b0;
    logic [7:0] curTx;
    int         waitCnt;
    int         violations = 0;
    logic       strayReq = 1'b0;

    initial begin
        bus.ByteDone = 1'b0;
        bus.RxByte   = 8'h00;
    end

    always @(negedge MasterCLK) begin
        bus.ByteDone = 1'b0;
        if (outstanding) begin
            if (bus.ByteStart) violations++;
            if (bus.TxByte !== curTx) violations++;
            if (waitCnt == 0) begin
                bus.ByteDone = 1'b1;
                bus.RxByte   = (rxQ.size() > 0) ? rxQ.pop_front() : 8'hFF;
                outstanding  = 1'b0;
            end else begin
                waitCnt--;
            end
        end else if (bus.ByteStart) begin
            recTx.push_back(bus.TxByte);
            recCs.push_back(CS_Enable);
            curTx       = bus.TxByte;
            outstanding = 1'b1;
            waitCnt     = $urandom_range(0, 3);
            if (strayReq) begin
                bus.ByteDone = 1'b1;
                bus.RxByte   = 8'h00;
                strayReq     = 1'b0;
            end
        end
    end

    // CRC7 as the remainder of (data * x^7) divided by x^7+x^3+1.
    function automatic logic [6:0] refCrc(input logic [39:0] d);
        logic [46:0] v;
        v = {d, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (v[b]) v = v ^ (47'h89 << (b - 7));
        return v[6:0];
    endfunction

    task automatic startCmd(input logic [5:0] idx, input logic [31:0] arg, input logic [2:0] rl);
        @(negedge MasterCLK);
        CmdIndex = idx;
        CmdArg   = arg;
        RespLen  = rl;
        CmdStart = 1'b1;
        @(negedge MasterCLK);
        CmdStart = 1'b0;
    endtask

    task automatic runCmd(input string name, input logic [5:0] idx, input logic [31:0] arg,
                          input logic [2:0] rl, input int nPoll, input logic [7:0] r1val,
                          input logic [31:0] respWord, input bit injectBusy,
                          input bit pokeAtDone);
        logic [7:0]  expTx[$];
        logic        expCs[$];
        logic [39:0] body;
        logic [47:0] fr;
        logic [31:0] expResp;
        logic [7:0]  expR1;
        bit          expTo;
        int          k, polls, doneCnt, post, recAtDone;
        logic        toAtDone;
        logic [7:0]  r1AtDone;
        logic [31:0] respAtDone;
        bit          finished;

        k     = (rl > 4) ? 4 : int'(rl);
        expTo = (nPoll >= NCR);
        polls = expTo ? NCR : nPoll + 1;
        body  = {2'b01, idx, arg};
        fr    = {body, refCrc(body), 1'b1};
        expR1 = expTo ? 8'hFF : {1'b0, r1val[6:0]};
        expResp = 32'h0;
        if (!expTo)
            for (int j = 0; j < k; j++) expResp[31 - 8*j -: 8] = respWord[31 - 8*j -: 8];

        rxQ.delete();
        recTx.delete();
        recCs.delete();
        violations = 0;
        for (int j = 0; j < 6; j++) begin
            expTx.push_back(fr[47 - 8*j -: 8]);
            expCs.push_back(1'b1);
            rxQ.push_back(8'($urandom));
        end
        for (int j = 0; j < polls; j++) begin
            expTx.push_back(8'hFF);
            expCs.push_back(1'b1);
            if (!expTo && j == nPoll) rxQ.push_back({1'b0, r1val[6:0]});
            else                      rxQ.push_back(8'h80 | 8'($urandom));
        end
        if (!expTo)
            for (int j = 0; j < k; j++) begin
                expTx.push_back(8'hFF);
                expCs.push_back(1'b1);
                rxQ.push_back(respWord[31 - 8*j -: 8]);
            end
        for (int j = 0; j < TRAIL; j++) begin
            expTx.push_back(8'hFF);
            expCs.push_back(1'b0);
            rxQ.push_back(8'($urandom));
        end

        startCmd(idx, arg, rl);
        checkVal({name, ".busy"}, 32'(Busy), 32'd1);

        doneCnt  = 0;
        post     = 0;
        finished = 0;
        recAtDone = 0;
        for (int c = 0; c < 3000 && !finished; c++) begin
            @(negedge MasterCLK);
            if (injectBusy && c == 2) begin
                CmdIndex = ~idx;
                CmdArg   = ~arg;
                CmdStart = 1'b1;
                strayReq = 1'b1;
            end else if (injectBusy && c == 3) begin
                CmdStart = 1'b0;
            end
            if (CmdDone) begin
                doneCnt++;
                toAtDone   = Timeout;
                r1AtDone   = R1;
                respAtDone = RespData;
                recAtDone  = recTx.size();
                if (pokeAtDone) begin
                    CmdIndex = 6'd1;
                    CmdStart = 1'b1;
                end
            end else if (doneCnt > 0) begin
                CmdStart = 1'b0;
                post++;
                if (post >= 4) finished = 1;
            end
        end
        CmdStart = 1'b0;

        checkVal({name, ".done_cnt"}, 32'(doneCnt), 32'd1);
        if (doneCnt > 0) begin
            checkVal({name, ".timeout"}, 32'(toAtDone), 32'(expTo));
            checkVal({name, ".r1"}, 32'(r1AtDone), 32'(expR1));
            checkVal({name, ".resp"}, respAtDone, expResp);
            checkVal({name, ".no_bytes_after_done"}, 32'(recTx.size()), 32'(recAtDone));
        end
        checkVal({name, ".byte_cnt"}, 32'(recTx.size()), 32'(expTx.size()));
        for (int j = 0; j < expTx.size() && j < recTx.size(); j++) begin
            checkVal($sformatf("%s.tx%0d", name, j), 32'(recTx[j]), 32'(expTx[j]));
            checkVal($sformatf("%s.cs%0d", name, j), 32'(recCs[j]), 32'(expCs[j]));
        end
        checkVal({name, ".handshake"}, 32'(violations), 32'd0);
        checkVal({name, ".idle_busy"}, 32'(Busy), 32'd0);
        checkVal({name, ".idle_cs"}, 32'(CS_Enable), 32'd0);
        checkVal({name, ".r1_hold"}, 32'(R1), 32'(expR1));
    endtask

    initial begin
        bit timedOut;
        Reset    = 1'b0;
        CmdStart = 1'b0;
        CmdIndex = '0;
        CmdArg   = '0;
        RespLen  = '0;
        repeat (3) @(negedge MasterCLK);
        checkVal("rst.busy", 32'(Busy), 32'd0);
        checkVal("rst.done", 32'(CmdDone), 32'd0);
        checkVal("rst.timeout", 32'(Timeout), 32'd0);
        checkVal("rst.r1", 32'(R1), 32'hFF);
        checkVal("rst.resp", RespData, 32'd0);
        checkVal("rst.txbyte", 32'(bus.TxByte), 32'hFF);
        checkVal("rst.bytestart", 32'(bus.ByteStart), 32'd0);
        checkVal("rst.cs", 32'(CS_Enable), 32'd0);
        Reset = 1'b1;

        runCmd("cmd0", 6'd0, 32'h0, 3'd0, 1, 8'h01, 32'h0, 0, 0);
        runCmd("cmd8", 6'd8, 32'h000001AA, 3'd4, 0, 8'h01, 32'h000001AA, 0, 0);
        runCmd("cmd17_to", 6'd17, 32'h0, 3'd0, 50, 8'h00, 32'h0, 0, 0);
        runCmd("cmd24_inj", 6'd24, 32'hDEADBEEF, 3'd1, 2, 8'h00, 32'h5A000000, 1, 1);

        // Abort CMD55 while byte 3 is on the wire.
        rxQ.delete();
        recTx.delete();
        startCmd(6'd55, 32'h0, 3'd0);
        timedOut = 1;
        for (int c = 0; c < 200; c++) begin
            @(negedge MasterCLK);
            #1;
            if (recTx.size() >= 4) begin
                timedOut = 0;
                break;
            end
        end
        checkVal("abort.reach_byte3", 32'(timedOut), 32'd0);
        Reset = 1'b0;
        @(posedge MasterCLK);
        #1;
        checkVal("abort.cs", 32'(CS_Enable), 32'd0);
        checkVal("abort.busy", 32'(Busy), 32'd0);
        checkVal("abort.bytestart", 32'(bus.ByteStart), 32'd0);
        checkVal("abort.done", 32'(CmdDone), 32'd0);
        outstanding = 1'b0;
        rxQ.delete();
        @(negedge MasterCLK);
        Reset = 1'b1;
        runCmd("cmd0_after", 6'd0, 32'h0, 3'd0, 0, 8'h01, 32'h0, 0, 0);

        runCmd("cmd58_rl7", 6'd58, 32'h0, 3'd7, 3, 8'h01, 32'hC0FF8000, 0, 0);

        for (int n = 0; n < 10; n++) begin
            runCmd($sformatf("rnd%0d", n), 6'($urandom), $urandom, 3'($urandom_range(0, 7)),
                   $urandom_range(0, 9), 8'($urandom), $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
